// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: RX FIFO bytes -> read/write register requests.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_cmd_parser #(
  parameter int W_REG          = 32,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ren,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [W_REG-1:0]  req_wdata,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef UART_CMD_CHECKSUM_EN
    CHK,
`endif
    ISSUE,
    ERR
  } state_t;

  state_t        state, next_state;
  logic          pop_q;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tcount;
  logic [1:0]    next_code;
  logic          accepting;
  logic          waiting;
  logic          timeout_hit;
  logic          is_read, is_write;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign is_read     = (rx_byte[7:5] == 3'b101);
  assign is_write    = (rx_byte[7:5] == 3'b100);
  assign timeout_hit = (tcount == TW'(TIMEOUT_CYCLES - 1));
  assign req_valid   = (state == ISSUE);
  assign err_pulse   = (state == ERR);

  // States that consume bytes; 'waiting' marks those where the timeout runs.
  always_comb begin
    accepting = 1'b0;
    waiting   = 1'b0;
    case (state)
      IDLE: accepting = 1'b1;
      DATA: begin accepting = 1'b1; waiting = 1'b1; end
`ifdef UART_CMD_CHECKSUM_EN
      CHK:  begin accepting = 1'b1; waiting = 1'b1; end
`endif
      default: ;
    endcase
  end

  // The forced gap after each pop gives the FIFO head a cycle to advance.
  assign rx_ren = !rst && rx_valid && !pop_q && accepting;

  always_comb begin
    next_state = state;
    next_code  = err_code;
    case (state)
      IDLE: if (rx_ren) begin
        if (is_read) begin
`ifdef UART_CMD_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = ISSUE;
`endif
        end else if (is_write) begin
          next_state = DATA;
        end else begin
          next_state = ERR;
          next_code  = 2'd1;
        end
      end
      DATA: begin
        if (rx_ren) begin
          if (byte_cnt == 2'd3) begin
`ifdef UART_CMD_CHECKSUM_EN
            next_state = CHK;
`else
            next_state = ISSUE;
`endif
          end
        end else if (timeout_hit) begin
          next_state = ERR;
          next_code  = 2'd2;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      CHK: begin
        if (rx_ren) begin
          if (rx_byte == csum) begin
            next_state = ISSUE;
          end else begin
            next_state = ERR;
            next_code  = 2'd3;
          end
        end else if (timeout_hit) begin
          next_state = ERR;
          next_code  = 2'd2;
        end
      end
`endif
      ISSUE: if (req_ready) next_state = IDLE;
      ERR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pop_q     <= 1'b0;
      byte_cnt  <= 2'd0;
      tcount    <= '0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      err_code  <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state    <= next_state;
      pop_q    <= rx_ren;
      err_code <= next_code;
      if (rx_ren || !waiting) begin
        tcount <= '0;
      end else begin
        tcount <= tcount + TW'(1);
      end
      if (state == IDLE && rx_ren && (is_read || is_write)) begin
        req_write <= is_write;
        req_addr  <= rx_byte[ADDR_W-1:0];
        req_wdata <= '0;
        byte_cnt  <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
        csum      <= rx_byte;
`endif
      end
      if (state == DATA && rx_ren) begin
        req_wdata[{byte_cnt, 3'b000} +: 8] <= rx_byte;
        byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
        csum     <= csum ^ rx_byte;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a queue-backed RX FIFO model.
// Runs in both builds; UART_CMD_CHECKSUM_EN adds checksum bytes and checksum cases.
module tb_uart_cmd_parser;

  localparam int TOUT = 16;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ren;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        err_pulse;
  logic [1:0]  err_code;

  logic [7:0] fifo_q[$];
  int         pop_log[$];
  int         cyc = 0;
  int         pop_count = 0;
  int         err_count = 0;
  int         req_cycles = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         pop_flag;

  always #5 clk = ~clk;

  uart_cmd_parser #(.W_REG(32), .ADDR_W(3), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ren(rx_ren),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .err_pulse(err_pulse), .err_code(err_code)
  );

  task automatic refresh();
    rx_valid = (fifo_q.size() > 0);
    rx_byte  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: the pop decision is sampled mid-cycle, the FIFO advances after the edge.
  task automatic tick();
    #1;
    pop_flag = rx_ren;
    @(posedge clk);
    #1;
    if (pop_flag) begin
      void'(fifo_q.pop_front());
      pop_log.push_back(cyc);
      pop_count++;
    end
    cyc++;
    refresh();
    @(negedge clk);
    if (err_pulse === 1'b1) err_count++;
    if (req_valid === 1'b1) req_cycles++;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendRead(input logic [7:0] cmd);
    applyStimulus(cmd);
    if (CSUM) applyStimulus(cmd);
  endtask

  task automatic sendWrite(input logic [7:0] cmd, input logic [31:0] data);
    logic [7:0] x;
    x = cmd;
    applyStimulus(cmd);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(data[8*k +: 8]);
      x = x ^ data[8*k +: 8];
    end
    if (CSUM) applyStimulus(x);
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, req_valid}, 32'd1);
  endtask

  task automatic waitErr(input string tag, input int budget);
    int n;
    n = 0;
    while (err_pulse !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, err_pulse}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rx_ren"},    {31'd0, rx_ren},    32'd0);
    checkOutput({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    checkOutput({tag, "_req_write"}, {31'd0, req_write}, 32'd0);
    checkOutput({tag, "_req_addr"},  {29'd0, req_addr},  32'd0);
    checkOutput({tag, "_req_wdata"}, req_wdata,          32'd0);
    checkOutput({tag, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
    checkOutput({tag, "_err_code"},  {30'd0, err_code},  32'd0);
  endtask

  initial begin
    int pc, ec, rc, bad;
    rst = 1'b1;
    req_ready = 1'b0;
    refresh();
    @(negedge clk);
    tick();
    sendRead(8'hA5);
    tick();
    tick();
    checkResetOutputs("reset");

    // Read 0xA5, already queued, consumed once reset releases.
    rst = 1'b0;
    req_ready = 1'b1;
    pc = pop_count;
    waitReq("rd_seen", 10);
    checkOutput("rd_write", {31'd0, req_write}, 32'd0);
    checkOutput("rd_addr", {29'd0, req_addr}, 32'd5);
    checkOutput("rd_wdata", req_wdata, 32'd0);
    checkOutput("rd_latency", cyc - pop_log[pop_log.size()-1], 32'd1);
    tick();
    checkOutput("rd_idle", {31'd0, req_valid}, 32'd0);
    repeat (3) tick();
    checkOutput("rd_pops", pop_count - pc, CSUM ? 32'd2 : 32'd1);

    // Little-endian write.
    sendWrite(8'h82, 32'h12345678);
    waitReq("wr_seen", 30);
    checkOutput("wr_write", {31'd0, req_write}, 32'd1);
    checkOutput("wr_addr", {29'd0, req_addr}, 32'd2);
    checkOutput("wr_wdata", req_wdata, 32'h12345678);
    checkOutput("wr_latency", cyc - pop_log[pop_log.size()-1], 32'd1);
    checkOutput("wr_frame_time", cyc - pop_log[pop_log.size() - (CSUM ? 6 : 5)], CSUM ? 32'd11 : 32'd9);
    tick();

    // Backpressure with a second frame waiting in the FIFO.
    req_ready = 1'b0;
    sendWrite(8'h81, 32'hDEADBEEF);
    sendRead(8'hA6);
    waitReq("bp_seen", 30);
    checkOutput("bp_wdata", req_wdata, 32'hDEADBEEF);
    pc = pop_count;
    ec = err_count;
    bad = 0;
    repeat (50) begin
      tick();
      if (req_valid !== 1'b1 || req_write !== 1'b1 || req_addr !== 3'd1 || req_wdata !== 32'hDEADBEEF) bad++;
    end
    checkOutput("bp_stable", bad, 32'd0);
    checkOutput("bp_no_pop", pop_count - pc, 32'd0);
    checkOutput("bp_no_err", err_count - ec, 32'd0);
    req_ready = 1'b1;
    tick();
    checkOutput("bp_accept", {31'd0, req_valid}, 32'd0);
    waitReq("bp2_seen", 20);
    checkOutput("bp2_write", {31'd0, req_write}, 32'd0);
    checkOutput("bp2_addr", {29'd0, req_addr}, 32'd6);
    tick();

    // Illegal opcode followed by a good read.
    applyStimulus(8'h20);
    sendRead(8'hA1);
    waitErr("ill_seen", 10);
    checkOutput("ill_code", {30'd0, err_code}, 32'd1);
    checkOutput("ill_latency", cyc - pop_log[pop_log.size()-1], 32'd1);
    tick();
    checkOutput("ill_one_cycle", {31'd0, err_pulse}, 32'd0);
    waitReq("ill_rd_seen", 20);
    checkOutput("ill_rd_addr", {29'd0, req_addr}, 32'd1);
    tick();

    // Timeout after a partial write.
    rc = req_cycles;
    applyStimulus(8'h80);
    applyStimulus(8'h11);
    waitErr("to_seen", 60);
    checkOutput("to_code", {30'd0, err_code}, 32'd2);
    checkOutput("to_delay", cyc - pop_log[pop_log.size()-1], 32'd17);
    checkOutput("to_no_req", req_cycles - rc, 32'd0);
    sendRead(8'hA3);
    waitReq("to_rd_seen", 20);
    checkOutput("to_rd_addr", {29'd0, req_addr}, 32'd3);
    tick();

`ifdef UART_CMD_CHECKSUM_EN
    applyStimulus(8'hA4);
    applyStimulus(8'hA4);
    waitReq("ck_rd_seen", 20);
    checkOutput("ck_rd_addr", {29'd0, req_addr}, 32'd4);
    tick();
    rc = req_cycles;
    applyStimulus(8'hA4);
    applyStimulus(8'h00);
    waitErr("ck_bad_seen", 20);
    checkOutput("ck_bad_code", {30'd0, err_code}, 32'd3);
    checkOutput("ck_bad_latency", cyc - pop_log[pop_log.size()-1], 32'd1);
    repeat (3) tick();
    checkOutput("ck_bad_no_req", req_cycles - rc, 32'd0);
`endif

    // Reset in the middle of a write frame.
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checkResetOutputs("midrst");
    fifo_q.delete();
    refresh();
    tick();
    rst = 1'b0;
    ec = err_count;
    rc = req_cycles;
    repeat (5) tick();
    checkOutput("midrst_no_err", err_count - ec, 32'd0);
    checkOutput("midrst_no_req", req_cycles - rc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
